// File: rtl/rb2_frame_rx_pkg.sv
// Shared constants and state encoding for the RB2 serial frame receiver.
package rb2_frame_rx_pkg;

  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned DATA_W     = 18;
  localparam int unsigned NUM_FRAMES = 8;

  localparam int unsigned FRAME_W  = ADDR_W + DATA_W;
  localparam int unsigned BITCNT_W = $clog2(FRAME_W);
  localparam int unsigned FRMCNT_W = $clog2(NUM_FRAMES + 1);
  localparam int unsigned ADDR_MSB = FRAME_W - 1;
  localparam int unsigned ADDR_LSB = DATA_W;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WRITE,
    ST_DONE
  } rx_state_t;

endpackage

// File: rtl/rb2_frame_rx_sd_deser.sv
// Serial-to-parallel frame capture: shift register plus bit counter, MSB first.
module sd_deser
  import rb2_frame_rx_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sen,
  input  logic               i_sd,
  output logic               o_frame_valid,
  output logic [FRAME_W-1:0] o_frame
);

  logic [FRAME_W-2:0]  r_shift;
  logic [BITCNT_W-1:0] r_bitcnt;
  logic                w_last;

  assign w_last = !i_sen && (r_bitcnt == BITCNT_W'(FRAME_W - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else if (i_sen) begin
      r_bitcnt <= '0;
    end else begin
      r_shift  <= {r_shift[FRAME_W-3:0], i_sd};
      r_bitcnt <= w_last ? '0 : r_bitcnt + 1'b1;
    end
  end

  // The final bit is taken straight from i_sd so the frame is presented on the
  // same edge that captures it; only the first FRAME_W-1 bits need storage.
  assign o_frame_valid = w_last;
  assign o_frame       = {r_shift, i_sd};

endmodule

// File: rtl/rb2_frame_rx.sv
// RB2 frame receiver: deserialises address/data frames and writes them into RB2.
module rb2_frame_rx
  import rb2_frame_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sd,
  output logic              RB2_RW,
  output logic [ADDR_W-1:0] RB2_A,
  output logic [DATA_W-1:0] RB2_D,
  input  logic [DATA_W-1:0] RB2_Q,
  output logic              S2_done,
  output logic              seq_err
);

  logic                w_frame_valid;
  logic [FRAME_W-1:0]  w_frame;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic                w_accept;
  logic                w_unused;

  rx_state_t           r_state;
  rx_state_t           w_next;
  logic [FRMCNT_W-1:0] r_frame_cnt;
  logic [ADDR_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_d;
  logic                r_seq_err;

  sd_deser u_deser (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_sen         (sen),
    .i_sd          (sd),
    .o_frame_valid (w_frame_valid),
    .o_frame       (w_frame)
  );

  assign w_addr   = w_frame[ADDR_MSB:ADDR_LSB];
  assign w_data   = w_frame[ADDR_LSB-1:0];
  assign w_unused = ^RB2_Q;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_frame_valid) begin
          w_accept = 1'b1;
          w_next   = ST_WRITE;
        end
      end
      // Counter was bumped on the accept edge, so it already reflects this write.
      ST_WRITE: w_next = (r_frame_cnt == FRMCNT_W'(NUM_FRAMES)) ? ST_DONE : ST_RUN;
      ST_DONE:  w_next = ST_DONE;
      default:  w_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_d         <= '0;
      r_frame_cnt <= '0;
      r_seq_err   <= 1'b0;
    end else if (w_accept) begin
      r_a <= w_addr;
      r_d <= w_data;
      if (FRMCNT_W'(w_addr) != r_frame_cnt) r_seq_err <= 1'b1;
      if (r_frame_cnt != FRMCNT_W'(NUM_FRAMES)) r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign RB2_RW  = (r_state != ST_WRITE);
  assign RB2_A   = r_a;
  assign RB2_D   = r_d;
  assign S2_done = (r_state == ST_DONE);
  assign seq_err = r_seq_err;

endmodule

// File: tb/tb_rb2_frame_rx.sv
// Directed self-checking bench for rb2_frame_rx with a behavioural RB2 model.
module tb_rb2_frame_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sen = 1'b1;
  logic        sd  = 1'b0;
  logic        RB2_RW;
  logic [2:0]  RB2_A;
  logic [17:0] RB2_D;
  logic [17:0] RB2_Q = '0;
  logic        S2_done;
  logic        seq_err;

  int vectors = 0;
  int errors  = 0;
  int wr_count = 0;
  logic [17:0] mem [8];

  always #5 clk = ~clk;

  rb2_frame_rx dut (
    .clk     (clk),
    .rst     (rst),
    .sen     (sen),
    .sd      (sd),
    .RB2_RW  (RB2_RW),
    .RB2_A   (RB2_A),
    .RB2_D   (RB2_D),
    .RB2_Q   (RB2_Q),
    .S2_done (S2_done),
    .seq_err (seq_err)
  );

  // RB2: synchronous write when WENn is low
  always @(posedge clk) begin
    if (RB2_RW === 1'b0) begin
      mem[RB2_A] = RB2_D;
      wr_count++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_model();
    for (int i = 0; i < 8; i++) mem[i] = '0;
    wr_count = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; sen = 1'b1; sd = 1'b0;
    @(negedge clk); rst = 1'b0;
    clear_model();
  endtask

  // Drives 21 bits; the posedge after return captures the last bit.
  task automatic send_frame(input logic [2:0] a, input logic [17:0] d);
    logic [20:0] f;
    f = {a, d};
    for (int i = 20; i >= 0; i--) begin
      @(negedge clk); sen = 1'b0; sd = f[i];
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(negedge clk); sen = 1'b1; end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (RB2_RW !== 1'b1) begin errors++; $display("FAIL reset_rw: got %b want 1", RB2_RW); end
    vectors++; if (RB2_A !== 3'd0) begin errors++; $display("FAIL reset_a: got %0h want 0", RB2_A); end
    vectors++; if (RB2_D !== 18'd0) begin errors++; $display("FAIL reset_d: got %0h want 0", RB2_D); end
    vectors++; if (S2_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", S2_done); end
    vectors++; if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq: got %b want 0", seq_err); end
  endtask

  task automatic test_full_sequence();
    logic [17:0] dat [8];
    dat = '{18'h00001, 18'h3FFFF, 18'h15555, 18'h2AAAA, 18'h00000, 18'h12345, 18'h0F0F0, 18'h30303};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send_frame(3'(i), dat[i]);
      idle(2);
    end
    vectors++; if (S2_done !== 1'b0) begin errors++; $display("FAIL full_done_early: got %b want 0", S2_done); end
    send_frame(3'd7, dat[7]);
    idle(1);
    vectors++; if (RB2_RW !== 1'b0 || RB2_A !== 3'd7 || RB2_D !== 18'h30303) begin
      errors++; $display("FAIL full_last_wr: got rw=%b a=%0h d=%0h want rw=0 a=7 d=30303", RB2_RW, RB2_A, RB2_D); end
    vectors++; if (S2_done !== 1'b0) begin errors++; $display("FAIL full_done_strobe: got %b want 0", S2_done); end
    idle(1);
    vectors++; if (S2_done !== 1'b1) begin errors++; $display("FAIL full_done: got %b want 1", S2_done); end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (mem[i] !== dat[i]) begin errors++; $display("FAIL full_mem%0d: got %0h want %0h", i, mem[i], dat[i]); end
    end
    vectors++; if (seq_err !== 1'b0) begin errors++; $display("FAIL full_seq: got %b want 0", seq_err); end
    vectors++; if (wr_count !== 8) begin errors++; $display("FAIL full_wrcnt: got %0d want 8", wr_count); end
  endtask

  task automatic test_single_frame();
    do_reset();
    send_frame(3'd3, 18'h2AAAA);
    vectors++; if (RB2_RW !== 1'b1) begin errors++; $display("FAIL single_pre: got %b want 1", RB2_RW); end
    idle(1);
    vectors++; if (RB2_RW !== 1'b0 || RB2_A !== 3'd3 || RB2_D !== 18'h2AAAA) begin
      errors++; $display("FAIL single_wr: got rw=%b a=%0h d=%0h want rw=0 a=3 d=2aaaa", RB2_RW, RB2_A, RB2_D); end
    idle(1);
    vectors++; if (RB2_RW !== 1'b1 || RB2_A !== 3'd3 || RB2_D !== 18'h2AAAA) begin
      errors++; $display("FAIL single_hold: got rw=%b a=%0h d=%0h want rw=1 a=3 d=2aaaa", RB2_RW, RB2_A, RB2_D); end
    idle(3);
    vectors++; if (wr_count !== 1) begin errors++; $display("FAIL single_wrcnt: got %0d want 1", wr_count); end
    vectors++; if (mem[3] !== 18'h2AAAA) begin errors++; $display("FAIL single_mem: got %0h want 2aaaa", mem[3]); end
  endtask

  task automatic test_partial_abort();
    logic [9:0] junk;
    junk = 10'b1101101011;
    do_reset();
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk); sen = 1'b0; sd = junk[i];
    end
    idle(2);
    vectors++; if (wr_count !== 0) begin errors++; $display("FAIL partial_nowr: got %0d want 0", wr_count); end
    send_frame(3'd0, 18'h11111);
    idle(2);
    send_frame(3'd1, 18'h0ABCD);
    idle(2);
    vectors++; if (mem[0] !== 18'h11111) begin errors++; $display("FAIL partial_mem0: got %0h want 11111", mem[0]); end
    vectors++; if (mem[1] !== 18'h0ABCD) begin errors++; $display("FAIL partial_mem1: got %0h want 0abcd", mem[1]); end
    vectors++; if (wr_count !== 2) begin errors++; $display("FAIL partial_wrcnt: got %0d want 2", wr_count); end
    // seq_err stays low only if the partial frame left the frame count at 0
    vectors++; if (seq_err !== 1'b0) begin errors++; $display("FAIL partial_seq: got %b want 0", seq_err); end
  endtask

  task automatic test_seq_error();
    logic [2:0] addrs [8];
    addrs = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd4, 3'd5, 3'd6, 3'd7};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_frame(addrs[i], 18'h00100 + 18'(i));
      idle(2);
      if (i == 2) begin
        vectors++; if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_before: got %b want 0", seq_err); end
      end
      if (i == 3) begin
        vectors++; if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_after4: got %b want 1", seq_err); end
        vectors++; if (mem[5] !== 18'h00103) begin errors++; $display("FAIL seq_mem5a: got %0h want 103", mem[5]); end
      end
    end
    vectors++; if (mem[3] !== 18'h0) begin errors++; $display("FAIL seq_mem3: got %0h want 0", mem[3]); end
    vectors++; if (mem[4] !== 18'h00104) begin errors++; $display("FAIL seq_mem4: got %0h want 104", mem[4]); end
    vectors++; if (mem[5] !== 18'h00105) begin errors++; $display("FAIL seq_mem5: got %0h want 105", mem[5]); end
    vectors++; if (S2_done !== 1'b1) begin errors++; $display("FAIL seq_done: got %b want 1", S2_done); end
    vectors++; if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_sticky: got %b want 1", seq_err); end
  endtask

  task automatic test_rst_abort();
    logic [20:0] f;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_frame(3'(i), 18'h00200 + 18'(i));
      idle(2);
    end
    f = {3'd3, 18'h12345};
    for (int i = 20; i >= 9; i--) begin
      @(negedge clk); sen = 1'b0; sd = f[i];
    end
    @(negedge clk); rst = 1'b1; sen = 1'b1;
    @(negedge clk); rst = 1'b0;
    vectors++; if (wr_count !== 3) begin errors++; $display("FAIL abort_nowr: got %0d want 3", wr_count); end
    vectors++; if (RB2_RW !== 1'b1 || RB2_A !== 3'd0 || RB2_D !== 18'd0) begin
      errors++; $display("FAIL abort_outs: got rw=%b a=%0h d=%0h want rw=1 a=0 d=0", RB2_RW, RB2_A, RB2_D); end
    clear_model();
    for (int i = 0; i < 8; i++) begin
      send_frame(3'(i), 18'h01000 + 18'(i));
      idle(2);
      if (i == 6) begin
        vectors++; if (S2_done !== 1'b0) begin errors++; $display("FAIL abort_done_early: got %b want 0", S2_done); end
      end
    end
    vectors++; if (S2_done !== 1'b1) begin errors++; $display("FAIL abort_done: got %b want 1", S2_done); end
    vectors++; if (wr_count !== 8) begin errors++; $display("FAIL abort_wrcnt: got %0d want 8", wr_count); end
    vectors++; if (mem[0] !== 18'h01000 || mem[7] !== 18'h01007) begin
      errors++; $display("FAIL abort_mem: got %0h/%0h want 1000/1007", mem[0], mem[7]); end
    vectors++; if (seq_err !== 1'b0) begin errors++; $display("FAIL abort_seq: got %b want 0", seq_err); end
  endtask

  task automatic test_after_done();
    send_frame(3'd2, 18'h3FFFF);
    idle(1);
    vectors++; if (RB2_RW !== 1'b1) begin errors++; $display("FAIL post_rw: got %b want 1", RB2_RW); end
    idle(3);
    vectors++; if (wr_count !== 8) begin errors++; $display("FAIL post_wrcnt: got %0d want 8", wr_count); end
    vectors++; if (mem[2] !== 18'h01002) begin errors++; $display("FAIL post_mem2: got %0h want 1002", mem[2]); end
    vectors++; if (S2_done !== 1'b1) begin errors++; $display("FAIL post_done: got %b want 1", S2_done); end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_single_frame();
    test_partial_abort();
    test_seq_error();
    test_rst_abort();
    test_after_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
